// File: rtl/door_event_encoder.sv
// Door-contact front end: synchronize, debounce and edge-detect three contacts, then serialize openings as codes 1..3.
// Optional macro HOLD_CODE_EN: o_code keeps the last emitted door number between events instead of returning to 0.
module door_event_encoder #(
    parameter int DEB_CYCLES = 4,
    parameter int BITS       = 2
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [2:0]      i_door_raw,
    output logic [BITS-1:0] o_code,
    output logic            o_code_valid,
    output logic [2:0]      o_pending
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(DEB_CYCLES - 1);

    logic [2:0] w_open;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_door
            logic       r_s1;
            logic       r_s2;
            logic       r_deb;
            logic [7:0] r_cnt;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_s1  <= 1'b0;
                    r_s2  <= 1'b0;
                    r_deb <= 1'b0;
                    r_cnt <= 8'd0;
                end else begin
                    r_s1 <= i_door_raw[gi];
                    r_s2 <= r_s1;
                    // Any sample matching the accepted level restarts the qualification window.
                    if (r_s2 == r_deb) begin
                        r_cnt <= 8'd0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_deb <= r_s2;
                        r_cnt <= 8'd0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
            end

            assign w_open[gi] = r_s2 && !r_deb && (r_cnt == CNT_LAST);
        end
    endgenerate

    state_t          r_state;
    state_t          w_state_next;
    logic [2:0]      r_pending;
    logic [2:0]      w_pending_next;
    logic [2:0]      w_sel;
    logic [BITS-1:0] r_code;
    logic [BITS-1:0] w_code_next;
    logic            r_code_valid;
    logic            w_valid_next;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_pending    <= 3'b000;
            r_code       <= '0;
            r_code_valid <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_pending    <= w_pending_next;
            r_code       <= w_code_next;
            r_code_valid <= w_valid_next;
        end
    end

    always_comb begin
        w_sel        = 3'b000;
        w_valid_next = 1'b0;
`ifdef HOLD_CODE_EN
        w_code_next  = r_code;
`else
        w_code_next  = '0;
`endif
        if (r_state == S_DRAIN) begin
            // Lowest-numbered door wins; the rest wait in pending for later cycles.
            if (r_pending[0]) begin
                w_sel       = 3'b001;
                w_code_next = BITS'(1);
            end else if (r_pending[1]) begin
                w_sel       = 3'b010;
                w_code_next = BITS'(2);
            end else begin
                w_sel       = 3'b100;
                w_code_next = BITS'(3);
            end
            w_valid_next = 1'b1;
        end
        w_pending_next = (r_pending & ~w_sel) | w_open;
        w_state_next   = (w_pending_next != 3'b000) ? S_DRAIN : S_IDLE;
    end

    assign o_code       = r_code;
    assign o_code_valid = r_code_valid;
    assign o_pending    = r_pending;

endmodule

// File: tb/tb_door_event_encoder.sv
// Bench for door_event_encoder: per-cycle reference model of sampling/debounce/serialization plus directed scenario tasks.
// Build with +define+HOLD_CODE_EN to check the held-code variant.
module tb_door_event_encoder;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] raw = 3'b000;
    logic [1:0] code;
    logic       valid;
    logic [2:0] pend;

    door_event_encoder #(.DEB_CYCLES(DEB), .BITS(2)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_door_raw  (raw),
        .o_code      (code),
        .o_code_valid(valid),
        .o_pending   (pend)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ev_code[$];
    int ev_cyc[$];

    // Reference model state: raw history per edge, accepted levels, pending set, expected outputs.
    logic [2:0] hist[$];
    logic [2:0] m_deb, m_pend, m_open, m_flip, m_h;
    logic [1:0] m_code;
    logic       m_valid;
    int         m_sz, m_j;
    bit         m_diff;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist.delete();
            for (int k = 0; k < DEB + 2; k++) hist.push_back(3'b000);
            m_deb = 3'b000; m_pend = 3'b000; m_code = 2'd0; m_valid = 1'b0;
        end else begin
            // A level is accepted once the value seen two edges late has differed from it for DEB edges in a row.
            hist.push_back(raw);
            m_sz = hist.size();
            m_open = 3'b000;
            m_flip = 3'b000;
            for (int d = 0; d < 3; d++) begin
                m_diff = 1'b1;
                for (int k = 0; k < DEB; k++) begin
                    m_h = hist[m_sz - 3 - k];
                    if (m_h[d] == m_deb[d]) m_diff = 1'b0;
                end
                if (m_diff) begin
                    m_flip[d] = 1'b1;
                    if (!m_deb[d]) m_open[d] = 1'b1;
                end
            end
            m_deb = m_deb ^ m_flip;
            if (m_pend != 3'b000) begin
                m_j = 3;
                for (int b = 2; b >= 0; b--) if (m_pend[b]) m_j = b;
                m_code = 2'(m_j + 1);
                m_valid = 1'b1;
                m_pend[m_j] = 1'b0;
            end else begin
                m_valid = 1'b0;
`ifndef HOLD_CODE_EN
                m_code = 2'd0;
`endif
            end
            m_pend = m_pend | m_open;
            while (hist.size() > DEB + 2) void'(hist.pop_front());
        end
        #1;
        if (rst_n && valid === 1'b1) begin
            ev_code.push_back(int'(code));
            ev_cyc.push_back(cyc);
        end
        total++;
        if (code !== m_code) begin
            bad++;
            $display("FAIL code cyc=%0d got=%0d want=%0d", cyc, code, m_code);
        end
        total++;
        if (valid !== m_valid) begin
            bad++;
            $display("FAIL code_valid cyc=%0d got=%0b want=%0b", cyc, valid, m_valid);
        end
        total++;
        if (pend !== m_pend) begin
            bad++;
            $display("FAIL pending cyc=%0d got=%b want=%b", cyc, pend, m_pend);
        end
    end

    task automatic run_until(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic clear_events;
        ev_code.delete();
        ev_cyc.delete();
    endtask

    task automatic test_reset;
        int c0;
        raw = 3'b111;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({code, valid, pend} !== 6'b0) begin
                bad++;
                $display("FAIL reset_hold got=%b want=000000", {code, valid, pend});
            end
        end
        clear_events();
        rst_n = 1'b1;
        c0 = cyc;
        run_until(c0 + 14);
        total++;
        if (ev_code.size() != 3) begin
            bad++;
            $display("FAIL reset_open_count got=%0d want=3", ev_code.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (ev_code[i] != i + 1 || ev_cyc[i] != c0 + 1 + DEB + 2 + i) begin
                    bad++;
                    $display("FAIL reset_open_ev%0d got=code%0d@%0d want=code%0d@%0d",
                             i, ev_code[i], ev_cyc[i], i + 1, c0 + 1 + DEB + 2 + i);
                end
            end
        end
        $display("test_reset: %0d events after release", ev_code.size());
    endtask

    task automatic test_single_open;
        int n;
        raw = 3'b000;
        run_until(cyc + 12);
        clear_events();
        raw = 3'b001;
        n = cyc + 1;
        run_until(n + 10);
        total++;
        if (ev_code.size() != 1) begin
            bad++;
            $display("FAIL single_count got=%0d want=1", ev_code.size());
        end else begin
            total++;
            if (ev_code[0] != 1 || ev_cyc[0] != n + DEB + 2) begin
                bad++;
                $display("FAIL single_ev got=code%0d@%0d want=code1@%0d", ev_code[0], ev_cyc[0], n + DEB + 2);
            end
        end
        clear_events();
        raw = 3'b000;
        run_until(cyc + 12);
        total++;
        if (ev_code.size() != 0) begin
            bad++;
            $display("FAIL close_no_event got=%0d want=0", ev_code.size());
        end
        $display("test_single_open: door1 at edge %0d", n);
    endtask

    task automatic test_glitch;
        clear_events();
        raw = 3'b010;
        repeat (3) @(negedge clk);
        raw = 3'b000;
        run_until(cyc + 12);
        total++;
        if (ev_code.size() != 0 || pend !== 3'b000) begin
            bad++;
            $display("FAIL glitch got=%0d events pend=%b want=0 events pend=000", ev_code.size(), pend);
        end
        $display("test_glitch: %0d events", ev_code.size());
    endtask

    task automatic test_simultaneous;
        int n;
        clear_events();
        raw = 3'b101;
        n = cyc + 1;
        run_until(n + DEB + 1);
        total++;
        if (pend !== 3'b101) begin
            bad++;
            $display("FAIL simul_pending got=%b want=101", pend);
        end
        run_until(n + 12);
        total++;
        if (ev_code.size() != 2) begin
            bad++;
            $display("FAIL simul_count got=%0d want=2", ev_code.size());
        end else begin
            total++;
            if (ev_code[0] != 1 || ev_code[1] != 3 || ev_cyc[0] != n + DEB + 2 || ev_cyc[1] != n + DEB + 3) begin
                bad++;
                $display("FAIL simul_ev got=%0d@%0d,%0d@%0d want=1@%0d,3@%0d",
                         ev_code[0], ev_cyc[0], ev_code[1], ev_cyc[1], n + DEB + 2, n + DEB + 3);
            end
        end
        raw = 3'b000;
        run_until(cyc + 12);
        $display("test_simultaneous: %0d events", ev_code.size());
    endtask

    task automatic test_two_doors;
        int n;
        logic [1:0] idle_a, idle_b;
`ifdef HOLD_CODE_EN
        idle_a = 2'd2; idle_b = 2'd3;
`else
        idle_a = 2'd0; idle_b = 2'd0;
`endif
        clear_events();
        raw = 3'b010;
        n = cyc + 1;
        run_until(n + 10);
        total++;
        if (code !== idle_a) begin
            bad++;
            $display("FAIL two_idle_code1 got=%0d want=%0d", code, idle_a);
        end
        run_until(n + 19);
        raw = 3'b110;
        run_until(n + 30);
        total++;
        if (code !== idle_b) begin
            bad++;
            $display("FAIL two_idle_code2 got=%0d want=%0d", code, idle_b);
        end
        total++;
        if (ev_code.size() != 2) begin
            bad++;
            $display("FAIL two_count got=%0d want=2", ev_code.size());
        end else begin
            total++;
            if (ev_code[0] != 2 || ev_code[1] != 3 || ev_cyc[0] != n + DEB + 2 || ev_cyc[1] != n + 20 + DEB + 2) begin
                bad++;
                $display("FAIL two_ev got=%0d@%0d,%0d@%0d want=2@%0d,3@%0d",
                         ev_code[0], ev_cyc[0], ev_code[1], ev_cyc[1], n + DEB + 2, n + 20 + DEB + 2);
            end
        end
        raw = 3'b000;
        run_until(cyc + 12);
        $display("test_two_doors: %0d events", ev_code.size());
    endtask

    task automatic test_reset_mid;
        int n;
        clear_events();
        raw = 3'b010;
        n = cyc + 1;
        run_until(n + 3);
        rst_n = 1'b0;
        #1;
        total++;
        if ({code, valid, pend} !== 6'b0) begin
            bad++;
            $display("FAIL reset_mid_async got=%b want=000000", {code, valid, pend});
        end
        raw = 3'b000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_until(cyc + 15);
        total++;
        if (ev_code.size() != 0) begin
            bad++;
            $display("FAIL reset_mid_events got=%0d want=0", ev_code.size());
        end
        clear_events();
        raw = 3'b101;
        n = cyc + 1;
        run_until(n + DEB + 2);
        total++;
        if (valid !== 1'b1 || code !== 2'd1) begin
            bad++;
            $display("FAIL reset_drain_pre got=v%0b c%0d want=v1 c1", valid, code);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({code, valid, pend} !== 6'b0) begin
            bad++;
            $display("FAIL reset_drain_async got=%b want=000000", {code, valid, pend});
        end
        raw = 3'b000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_until(cyc + 15);
        total++;
        if (ev_code.size() != 1) begin
            bad++;
            $display("FAIL reset_drain_events got=%0d want=1", ev_code.size());
        end
        $display("test_reset_mid: %0d events", ev_code.size());
    endtask

    task automatic test_random;
        logic [2:0] flip;
        clear_events();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            flip = 3'b000;
            for (int d = 0; d < 3; d++) if ($urandom_range(0, 5) == 0) flip[d] = 1'b1;
            raw = raw ^ flip;
        end
        raw = 3'b000;
        run_until(cyc + 15);
        $display("test_random: %0d events", ev_code.size());
    endtask

    initial begin
        test_reset();
        test_single_open();
        test_glitch();
        test_simultaneous();
        test_two_doors();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
